// File: rtl/pwm_ctrl_pkg.sv
// ============================================================================
// Module      : pwm_ctrl_pkg
// Description : Shared types and defaults for the PWM duty ramp controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_ctrl_pkg;

  typedef enum logic {
    S_IDLE,
    S_RAMP
  } ramp_state_t;

  localparam int DUTY_W_DEF = 2;

  typedef logic [DUTY_W_DEF-1:0] duty_t;

endpackage : pwm_ctrl_pkg

`default_nettype wire

// File: rtl/pwm_ramp_controller_if.sv
// ============================================================================
// Module      : pwm_ramp_controller_if
// Description : Request handshake, emergency stop and duty/status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pwm_ramp_controller_if #(
  parameter int DUTY_W = pwm_ctrl_pkg::DUTY_W_DEF
);

  logic              req_valid;
  logic [DUTY_W-1:0] req_target;
  logic              req_ready;
  logic              stop;
  logic [DUTY_W-1:0] duty_cycle;
  logic              busy;
  logic              done;

  // Control side drives requests and stop; the ramp controller owns the rest.
  modport master (
    output req_valid,
    output req_target,
    output stop,
    input  req_ready,
    input  duty_cycle,
    input  busy,
    input  done
  );

  modport slave (
    input  req_valid,
    input  req_target,
    input  stop,
    output req_ready,
    output duty_cycle,
    output busy,
    output done
  );

endinterface : pwm_ramp_controller_if

`default_nettype wire

// File: rtl/pwm_step_timer.sv
// ============================================================================
// Module      : pwm_step_timer
// Description : Free-running step divider; one-cycle tick when the count wraps.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_step_timer #(
  parameter int STEP_CYCLES = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam int              CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(STEP_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             wrap;

  assign wrap = (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = wrap ? '0 : count_q + CNT_W'(1);
    end
  end

  // Clear wins over enable so an accept edge never produces a stray tick.
  assign tick_o = enable_i && !clear_i && wrap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule : pwm_step_timer

`default_nettype wire

// File: rtl/pwm_ramp_controller.sv
// ============================================================================
// Module      : pwm_ramp_controller
// Description : Steps the PWM duty level toward a requested target, one level
//               per STEP_CYCLES clocks, with an overriding emergency stop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_ramp_controller
  import pwm_ctrl_pkg::*;
#(
  parameter int DUTY_W      = DUTY_W_DEF,
  parameter int STEP_CYCLES = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  pwm_ramp_controller_if.slave  ctrl
);

  ramp_state_t       state_q;
  ramp_state_t       state_d;
  logic [DUTY_W-1:0] duty_q;
  logic [DUTY_W-1:0] duty_d;
  logic [DUTY_W-1:0] target_q;
  logic [DUTY_W-1:0] target_d;
  logic              done_q;
  logic              done_d;
  logic              tmr_clear;
  logic              tmr_enable;
  logic              tmr_tick;
  logic              req_ready;

  assign req_ready = (state_q == S_IDLE) && !ctrl.stop;

  pwm_step_timer #(
    .STEP_CYCLES (STEP_CYCLES)
  ) u_step_timer (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (tmr_clear),
    .enable_i (tmr_enable),
    .tick_o   (tmr_tick)
  );

  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    target_d   = target_q;
    done_d     = 1'b0;
    tmr_clear  = 1'b0;
    tmr_enable = 1'b0;

    if (ctrl.stop) begin
      state_d   = S_IDLE;
      duty_d    = '0;
      target_d  = '0;
      tmr_clear = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ctrl.req_valid) begin
            if (ctrl.req_target != duty_q) begin
              target_d  = ctrl.req_target;
              tmr_clear = 1'b1;
              state_d   = S_RAMP;
            end else begin
              done_d = 1'b1;
            end
          end
        end

        S_RAMP: begin
          tmr_enable = 1'b1;
          if (tmr_tick) begin
            // target_q is in range and differs from duty_q, so no wrap is possible.
            duty_d = (duty_q < target_q) ? duty_q + DUTY_W'(1)
                                         : duty_q - DUTY_W'(1);
            if (duty_d == target_q) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      duty_q   <= '0;
      target_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      done_q   <= done_d;
    end
  end

  assign ctrl.req_ready  = req_ready;
  assign ctrl.duty_cycle = duty_q;
  assign ctrl.busy       = (state_q == S_RAMP);
  assign ctrl.done       = done_q;

endmodule : pwm_ramp_controller

`default_nettype wire

// File: tb/tb_pwm_ramp_controller.sv
// ============================================================================
// Module      : tb_pwm_ramp_controller
// Description : Scoreboard bench for the duty ramp controller (STEP_CYCLES=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_ramp_controller;
  import pwm_ctrl_pkg::*;

  localparam int DUTY_W = 2;
  localparam int STEP   = 4;

  typedef struct {
    int   cyc;
    int   duty;
    logic busy;
    logic done;
    logic ready;
  } ev_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;
  bit   mon_en;
  ev_t  exp_q[$];

  pwm_ramp_controller_if #(.DUTY_W(DUTY_W)) ctrl_if ();

  pwm_ramp_controller #(
    .DUTY_W      (DUTY_W),
    .STEP_CYCLES (STEP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (ctrl_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(input int c, input int d, input logic b,
                               input logic dn, input logic r);
    ev_t e;
    e.cyc = c; e.duty = d; e.busy = b; e.done = dn; e.ready = r;
    exp_q.push_back(e);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Every change of the observable outputs must match the next queued event.
  initial begin : monitor
    logic [4:0] prev;
    logic [4:0] cur;
    ev_t        e;
    prev = {2'd0, 1'b0, 1'b0, 1'b1};
    wait (mon_en);
    forever begin
      @(posedge clk);
      #1;
      cur = {ctrl_if.duty_cycle, ctrl_if.busy, ctrl_if.done, ctrl_if.req_ready};
      if (cur !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: cyc=%0d duty=%0d busy=%0b done=%0b ready=%0b",
                   cyc, ctrl_if.duty_cycle, ctrl_if.busy, ctrl_if.done, ctrl_if.req_ready);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.duty != int'(ctrl_if.duty_cycle) ||
              e.busy !== ctrl_if.busy || e.done !== ctrl_if.done ||
              e.ready !== ctrl_if.req_ready) begin
            errors++;
            $display("FAIL event: got cyc=%0d duty=%0d busy=%0b done=%0b ready=%0b expected cyc=%0d duty=%0d busy=%0b done=%0b ready=%0b",
                     cyc, ctrl_if.duty_cycle, ctrl_if.busy, ctrl_if.done, ctrl_if.req_ready,
                     e.cyc, e.duty, e.busy, e.done, e.ready);
          end
        end
        prev = cur;
      end
    end
  end

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d events outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // Drives a request at a negedge; the following posedge is the accept edge.
  task automatic issue(input int t, output int acc);
    @(negedge clk);
    ctrl_if.req_valid  = 1'b1;
    ctrl_if.req_target = DUTY_W'(t);
    acc = cyc + 1;
  endtask

  task automatic drop_valid();
    @(negedge clk);
    ctrl_if.req_valid = 1'b0;
  endtask

  initial begin : stimulus
    int a;
    duty_t dchk;
    checks = 0;
    errors = 0;
    mon_en = 1'b0;
    ctrl_if.req_valid  = 1'b0;
    ctrl_if.req_target = '0;
    ctrl_if.stop       = 1'b0;
    reset = 1'b1;

    // 1: reset acts before any clock edge
    #2;
    dchk = ctrl_if.duty_cycle;
    check("rst_async_duty", int'(dchk), 0);
    check("rst_async_busy", int'(ctrl_if.busy), 0);
    check("rst_async_done", int'(ctrl_if.done), 0);
    check("rst_async_ready", int'(ctrl_if.req_ready), 1);
    #18;
    reset = 1'b0;
    mon_en = 1'b1;
    #1;
    check("rst_duty", int'(ctrl_if.duty_cycle), 0);
    check("rst_busy", int'(ctrl_if.busy), 0);
    check("rst_done", int'(ctrl_if.done), 0);
    check("rst_ready", int'(ctrl_if.req_ready), 1);

    // 2: ramp 0 -> 3
    issue(3, a);
    push(a,      0, 1, 0, 0);
    push(a + 4,  1, 1, 0, 0);
    push(a + 8,  2, 1, 0, 0);
    push(a + 12, 3, 0, 1, 1);
    push(a + 13, 3, 0, 0, 1);
    drop_valid();
    drain("ramp_up");

    // 3: ramp 3 -> 1 with a held request for 0 taken only once ready returns
    issue(1, a);
    push(a,      3, 1, 0, 0);
    push(a + 4,  2, 1, 0, 0);
    push(a + 8,  1, 0, 1, 1);
    push(a + 9,  1, 1, 0, 0);
    push(a + 13, 0, 0, 1, 1);
    push(a + 14, 0, 0, 0, 1);
    @(negedge clk);
    ctrl_if.req_target = 2'd0;
    while (cyc < a + 9) @(negedge clk);
    ctrl_if.req_valid = 1'b0;
    drain("ramp_down_held");

    // back to duty 1
    issue(1, a);
    push(a,     0, 1, 0, 0);
    push(a + 4, 1, 0, 1, 1);
    push(a + 5, 1, 0, 0, 1);
    drop_valid();
    drain("ramp_to_1");

    // 4: request equal to current duty
    issue(1, a);
    push(a,     1, 0, 1, 1);
    push(a + 1, 1, 0, 0, 1);
    drop_valid();
    drain("same_target");

    // back to duty 0
    issue(0, a);
    push(a,     1, 1, 0, 0);
    push(a + 4, 0, 0, 1, 1);
    push(a + 5, 0, 0, 0, 1);
    drop_valid();
    drain("ramp_to_0");

    // 5: emergency stop at duty 2 during 0 -> 3
    issue(3, a);
    push(a,      0, 1, 0, 0);
    push(a + 4,  1, 1, 0, 0);
    push(a + 8,  2, 1, 0, 0);
    push(a + 9,  0, 0, 0, 0);
    push(a + 12, 0, 0, 0, 1);
    drop_valid();
    while (cyc < a + 8) @(negedge clk);
    ctrl_if.stop       = 1'b1;
    ctrl_if.req_valid  = 1'b1;
    ctrl_if.req_target = 2'd2;
    #1;
    check("stop_ready", int'(ctrl_if.req_ready), 0);
    repeat (3) @(negedge clk);
    ctrl_if.stop      = 1'b0;
    ctrl_if.req_valid = 1'b0;
    drain("stop");

    issue(2, a);
    push(a,     0, 1, 0, 0);
    push(a + 4, 1, 1, 0, 0);
    push(a + 8, 2, 0, 1, 1);
    push(a + 9, 2, 0, 0, 1);
    drop_valid();
    drain("after_stop");

    // 6: asynchronous reset mid-ramp at duty 1
    issue(0, a);
    push(a,     2, 1, 0, 0);
    push(a + 4, 1, 1, 0, 0);
    push(a + 6, 0, 0, 0, 1);
    drop_valid();
    while (cyc < a + 5) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midramp_rst_duty", int'(ctrl_if.duty_cycle), 0);
    check("midramp_rst_busy", int'(ctrl_if.busy), 0);
    check("midramp_rst_done", int'(ctrl_if.done), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_ready", int'(ctrl_if.req_ready), 1);
    drain("midramp_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pwm_ramp_controller

`default_nettype wire
